spi_reg_sequencer: RTL and testbench
====================================

Name: spi_reg_sequencer

Overview:
- Sequences register-bank accesses for the SPI slave path. Sits between the SPI byte shifter (rx/tx bytes) and the digitizer configuration register bank.
- Decodes the first byte of each chip-select frame as command plus start address. Then runs burst reads or writes with address auto-increment, and loads read data into the tx shifter.
- Rejects invalid commands and byte overruns, and counts them.

Parameters:
- ADDR_W, 4, register address width; the start address field is rx_byte[ADDR_W-1:0] with ADDR_W<=4.
- DATA_W, 8, register data width; equals the SPI byte width.
- RD_CMD, 4'h1, command nibble for a burst read.
- WR_CMD, 4'h2, command nibble for a burst write.
- RD_LAT, 1, register-bank read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs_n  in  1  SPI chip select, already synchronized to clk; low = frame active.
- rx_byte  in  8  received byte; valid when rx_valid=1.
- rx_valid  in  1  one-cycle pulse per completed received byte.
- tx_byte  out  8  next byte for the tx shifter.
- tx_load  out  1  one-cycle pulse; shifter loads tx_byte.
- reg_addr  out  ADDR_W  register bank address.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  DATA_W  read data, valid RD_LAT cycles after reg_rd.
- reg_wr  out  1  one-cycle write strobe.
- reg_wdata  out  DATA_W  write data.
- busy  out  1  high whenever state != IDLE.
- err_cnt  out  8  saturating error counter.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; tx_byte, tx_load, reg_addr, reg_rd, reg_wr, reg_wdata, busy, err_cnt all 0. All outputs are registered.
- States: IDLE, CMD, RD_ISSUE, RD_WAIT, RD_LOAD, RD_HOLD, WR_DATA, DISCARD.
- cs_n high in any state: next state is IDLE. An rx_valid in the same cycle is dropped and no strobe is produced. cs_n has priority over every other event.
- IDLE -> CMD when cs_n is low.
- CMD, on rx_valid: latch the address from rx_byte[ADDR_W-1:0] and decode rx_byte[7:4]:
  - RD_CMD: go to RD_ISSUE.
  - WR_CMD: go to WR_DATA.
  - Any other nibble: err_cnt+1, go to DISCARD.
- RD_ISSUE: reg_rd=1 for exactly one cycle at reg_addr, then go to RD_WAIT.
- RD_WAIT: count RD_LAT cycles.
  - Capture reg_rdata at the end of cycle N+RD_LAT, where N is the reg_rd cycle.
  - tx_load=1 with tx_byte=captured data in cycle N+RD_LAT+1 (RD_LOAD).
  - reg_addr increments modulo 2^ADDR_W after capture.
- RD_LOAD -> RD_HOLD. In RD_HOLD, rx_valid (dummy byte clocked in while data shifts out) -> RD_ISSUE for the next address.
- Read overrun: rx_valid in RD_ISSUE, RD_WAIT or RD_LOAD.
  - err_cnt+1 and the byte is ignored.
  - The in-flight read still completes and loads tx.
- Read abort: cs_n high during RD_WAIT means the issued read finishes on the bank side. tx_load is suppressed and the address is not incremented.
- WR_DATA, on rx_valid in cycle t:
  - Cycle t+1: reg_wr=1, reg_wdata=rx_byte, reg_addr=current address.
  - Cycle t+2: address increments modulo 2^ADDR_W.
  - Remain in WR_DATA; back-to-back rx_valid on consecutive cycles is legal.
- DISCARD: ignore all rx_valid (no further err_cnt increments) until cs_n high.
- err_cnt saturates at 8'hFF. It clears only on reset.
- Address wrap: after address 4'hF the next access targets 4'h0. No error is raised.
- reg_rd and reg_wr are never high in the same cycle.

Test Plan:
- Burst write: cs_n low, rx 8'h23, 8'hAA, 8'h55, cs_n high -> reg_wr at addr 3 with data AA, then at addr 4 with data 55; err_cnt=0; busy falls the cycle after cs_n rises.
- Burst read, RD_LAT=2, bank addr5=8'h11, addr6=8'h22: rx 8'h15 -> reg_rd at addr 5, tx_load with 8'h11 exactly 3 cycles later; dummy rx -> reg_rd at addr 6, tx_load with 8'h22.
- Wrap: write command 8'h2F then 2 data bytes -> writes to addr F then addr 0.
- Invalid command 8'h7x -> no strobes for the rest of the frame, err_cnt=1; after 300 such frames err_cnt=8'hFF.
- Overrun: rx_valid during RD_WAIT -> err_cnt+1, the pending tx_load still occurs. cs_n rise during RD_WAIT -> no tx_load, state IDLE next cycle.
- Reset mid-write (rst_n pulsed low during WR_DATA) -> all outputs 0 immediately; next frame decodes its first byte as a command.

Source files
------------

// File: rtl/spi_reg_sequencer.sv
// SPI slave register sequencer: decodes a command byte per chip-select
// frame, then runs burst reads/writes with address auto-increment.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cs_n, rx_byte/valid   frame select and received bytes
//   tx_byte, tx_load      byte handed to the tx shifter
//   reg_addr/rd/rdata     register bank read side
//   reg_wr/wdata          register bank write side
//   busy, err_cnt         frame activity, saturating error count
module spi_reg_sequencer #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter logic [3:0]  RD_CMD = 4'h1,
  parameter logic [3:0]  WR_CMD = 4'h2,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              reg_wr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [2:0] {
    IDLE, CMD, RD_ISSUE, RD_WAIT,
    RD_LOAD, RD_HOLD, WR_DATA, DISCARD
  } state_e;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic                ld_q, ld_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                busy_q, busy_d;
  logic [7:0]          err_q, err_d;
  logic                err_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      tx_q    <= '0;
      ld_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdat_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      ld_q    <= ld_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    ld_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdat_d  = wdat_q;
    err_inc = 1'b0;
    if (cs_n) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (rx_valid) begin
            addr_d = rx_byte[ADDR_W-1:0];
            if (rx_byte[7:4] == RD_CMD) begin
              state_d = RD_ISSUE;
              rd_d    = 1'b1;
            end else if (rx_byte[7:4] == WR_CMD) begin
              state_d = WR_DATA;
            end else begin
              err_inc = 1'b1;
              state_d = DISCARD;
            end
          end
        end
        RD_ISSUE: begin
          err_inc = rx_valid;
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          err_inc = rx_valid;
          if (cnt_q == LAT_M1) begin
            tx_d    = reg_rdata;
            ld_d    = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = RD_LOAD;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        RD_LOAD: begin
          err_inc = rx_valid;
          state_d = RD_HOLD;
        end
        RD_HOLD: begin
          // Dummy byte in means the master wants the next register.
          if (rx_valid) begin
            state_d = RD_ISSUE;
            rd_d    = 1'b1;
          end
        end
        WR_DATA: begin
          // Bump address the cycle after the write strobe.
          if (wr_q) addr_d = addr_q + 1'b1;
          if (rx_valid) begin
            wr_d   = 1'b1;
            wdat_d = rx_byte[DATA_W-1:0];
          end
        end
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    err_d  = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign tx_byte   = tx_q;
  assign tx_load   = ld_q;
  assign reg_addr  = addr_q;
  assign reg_rd    = rd_q;
  assign reg_wr    = wr_q;
  assign reg_wdata = wdat_q;
  assign busy      = busy_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Testbench for spi_reg_sequencer: cycle vector table plus
// hand sequences for saturation and mid-frame reset.
module tb_spi_reg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [3:0] reg_addr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic       busy;
  logic [7:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_reg_sequencer #(.RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n),
    .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_load(tx_load),
    .reg_addr(reg_addr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .busy(busy),
    .err_cnt(err_cnt)
  );

  // Register bank model, read latency 2.
  logic [7:0] bank [16];
  logic       p1v;
  logic [7:0] p1;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'(i * 17);
      bank[5]   <= 8'h11;
      bank[6]   <= 8'h22;
      p1v       <= 1'b0;
      p1        <= 8'h00;
      reg_rdata <= 8'hEE;
    end else begin
      if (reg_wr) bank[reg_addr] <= reg_wdata;
      p1v       <= reg_rd;
      p1        <= bank[reg_addr];
      reg_rdata <= p1v ? p1 : 8'hEE;
    end
  end

  typedef struct {
    logic       c;
    logic       v;
    logic [7:0] b;
    logic       wr;
    logic       rd;
    logic       ld;
    logic [3:0] addr;
    logic [7:0] data;
    logic       busy;
    logic [7:0] err;
  } vec_t;

  vec_t tbl[$];
  logic strobe_seen;

  function automatic vec_t V(
    input logic c, input logic v, input logic [7:0] b,
    input logic wr, input logic rd, input logic ld,
    input logic [3:0] a, input logic [7:0] d,
    input logic bz, input logic [7:0] e);
    vec_t r;
    r.c = c; r.v = v; r.b = b;
    r.wr = wr; r.rd = rd; r.ld = ld;
    r.addr = a; r.data = d; r.busy = bz; r.err = e;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic step(input logic c, input logic v,
                      input logic [7:0] b);
    cs_n = c; rx_valid = v; rx_byte = b;
    @(posedge clk); #1;
    if (reg_wr || reg_rd || tx_load) strobe_seen = 1'b1;
  endtask

  function automatic logic [31:0] all_outs();
    return {tx_byte, tx_load, reg_addr, reg_rd,
            reg_wr, reg_wdata, busy, err_cnt};
  endfunction

  initial begin
    logic [23:0] g, x;
    // c v b       wr rd ld addr data busy err
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h0,8'h00,0,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h0,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h23, 0,0,0,4'h3,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'hAA, 1,0,0,4'h3,8'hAA,1,8'd0));
    tbl.push_back(V(0,1,8'h55, 1,0,0,4'h4,8'h55,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h5,8'h00,1,8'd0));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h5,8'h00,0,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h5,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h15, 0,1,0,4'h5,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h5,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h5,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,1,4'h6,8'h11,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h6,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h00, 0,1,0,4'h6,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h6,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h6,8'h00,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,1,4'h7,8'h22,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h7,8'h00,1,8'd0));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h7,8'h00,0,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h7,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h2F, 0,0,0,4'hF,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h01, 1,0,0,4'hF,8'h01,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h0,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h02, 1,0,0,4'h0,8'h02,1,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h1,8'h00,1,8'd0));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h1,8'h00,0,8'd0));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h1,8'h00,1,8'd0));
    tbl.push_back(V(0,1,8'h73, 0,0,0,4'h3,8'h00,1,8'd1));
    tbl.push_back(V(0,1,8'h23, 0,0,0,4'h3,8'h00,1,8'd1));
    tbl.push_back(V(0,1,8'h15, 0,0,0,4'h3,8'h00,1,8'd1));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h3,8'h00,0,8'd1));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h3,8'h00,1,8'd1));
    tbl.push_back(V(0,1,8'h18, 0,1,0,4'h8,8'h00,1,8'd1));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h8,8'h00,1,8'd1));
    tbl.push_back(V(0,1,8'hFF, 0,0,0,4'h8,8'h00,1,8'd2));
    tbl.push_back(V(0,0,8'h00, 0,0,1,4'h9,8'h88,1,8'd2));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h9,8'h00,1,8'd2));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'h9,8'h00,0,8'd2));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'h9,8'h00,1,8'd2));
    tbl.push_back(V(0,1,8'h1A, 0,1,0,4'hA,8'h00,1,8'd2));
    tbl.push_back(V(0,0,8'h00, 0,0,0,4'hA,8'h00,1,8'd2));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'hA,8'h00,0,8'd2));
    tbl.push_back(V(1,0,8'h00, 0,0,0,4'hA,8'h00,0,8'd2));

    strobe_seen = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].v, tbl[i].b);
      g[15:0] = {reg_wr, reg_rd, tx_load, reg_addr, busy, err_cnt};
      x[15:0] = {tbl[i].wr, tbl[i].rd, tbl[i].ld, tbl[i].addr,
                 tbl[i].busy, tbl[i].err};
      g[23:16] = reg_wr ? reg_wdata : (tx_load ? tx_byte : 8'h00);
      x[23:16] = (tbl[i].wr || tbl[i].ld) ? tbl[i].data : 8'h00;
      chk($sformatf("vec%0d", i), {8'h0, g}, {8'h0, x});
    end

    // Invalid-command frames until err_cnt saturates.
    strobe_seen = 1'b0;
    for (int f = 0; f < 300; f++) begin
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h70 | 8'(f & 15));
      step(1'b0, 1'b1, 8'h21);
      step(1'b1, 1'b0, 8'h00);
      if (f == 99) chk("err_102", {24'h0, err_cnt}, 32'd102);
    end
    chk("err_sat", {24'h0, err_cnt}, 32'hFF);
    chk("discard_nostrobe", {31'h0, strobe_seen}, 32'h0);

    // Reset while a write is in progress.
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h24);
    step(1'b0, 1'b1, 8'h99);
    chk("wr_before_rst", {reg_wr, reg_addr, reg_wdata},
        {1'b1, 4'h4, 8'h99});
    rst_n = 1'b0;
    #1;
    chk("async_rst", all_outs(), 32'h0);
    cs_n = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_busy", {31'h0, busy}, 32'h1);
    step(1'b0, 1'b1, 8'h16);
    chk("post_rst_rd", {reg_rd, reg_wr, reg_addr},
        {1'b1, 1'b0, 4'h6});
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("post_rst_ld", {tx_load, tx_byte, reg_addr, err_cnt},
        {1'b1, 8'h22, 4'h7, 8'h00});
    step(1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
